uart_wb_bridge: RTL and testbench

Parametrised byte-stream to Wishbone master bridge for board-level DDR3 bring-up. It sits between the UART's AXI-stream byte ports and ddr3_top's pipelined Wishbone slave port. It replaces single-character poke logic with framed commands carrying full-width address and data, and returns read data or a status byte to the UART TX stream.

---
 rtl/uart_wb_bridge_pkg.sv | 28 ++
 rtl/uart_wb_bridge_if.sv | 44 ++++
 rtl/uart_wb_bridge_tx_serializer.sv | 66 ++++++
 rtl/uart_wb_bridge.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_wb_bridge.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_wb_bridge_pkg.sv
// uart_wb_bridge_pkg
// Shared constants for the UART-to-Wishbone bridge: FSM state encodings,
// command/response byte values and a byte-count helper.
// No ports (package).
package uart_wb_bridge_pkg;

    // Command bytes accepted in IDLE
    localparam logic [7:0] CMD_WR = 8'h57;  // 'W'
    localparam logic [7:0] CMD_RD = 8'h52;  // 'R'

    // Response bytes
    localparam logic [7:0] RSP_OK = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_TO = 8'h54;  // 'T'

    // FSM state encodings (legacy-compatible constants)
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_GET_ADDR  = 3'd1;
    localparam logic [2:0] ST_GET_DATA  = 3'd2;
    localparam logic [2:0] ST_WB_REQ    = 3'd3;
    localparam logic [2:0] ST_WB_WAIT   = 3'd4;
    localparam logic [2:0] ST_SEND_RESP = 3'd5;

    // Number of whole bytes needed to carry 'bits' bits
    function automatic int unsigned bytes_for_bits(input int unsigned bits);
        return (bits + 32'd7) / 32'd8;
    endfunction

endpackage

// File: rtl/uart_wb_bridge_if.sv
// uart_wb_bridge_if
// Bundles the UART AXI-stream byte ports and the pipelined Wishbone master
// port of the bridge. Signal names keep the original port names.
//   modport master : the bridge side (drives o_*, samples i_*)
//   modport slave  : the environment side (UART + Wishbone slave)
// Signals:
//   i_rx_data/i_rx_valid/o_rx_ready   received byte stream
//   o_tx_data/o_tx_valid/i_tx_ready   response byte stream
//   o_wb_cyc/stb/we/addr/data/sel     Wishbone request
//   i_wb_stall/i_wb_ack/i_wb_data     Wishbone response
interface uart_wb_bridge_if #(
    parameter int unsigned WB_ADDR_BITS = 32,
    parameter int unsigned WB_DATA_BITS = 32,
    parameter int unsigned WB_SEL_BITS  = WB_DATA_BITS / 8
);
    logic [7:0]              i_rx_data;
    logic                    i_rx_valid;
    logic                    o_rx_ready;
    logic [7:0]              o_tx_data;
    logic                    o_tx_valid;
    logic                    i_tx_ready;
    logic                    o_wb_cyc;
    logic                    o_wb_stb;
    logic                    o_wb_we;
    logic [WB_ADDR_BITS-1:0] o_wb_addr;
    logic [WB_DATA_BITS-1:0] o_wb_data;
    logic [WB_SEL_BITS-1:0]  o_wb_sel;
    logic                    i_wb_stall;
    logic                    i_wb_ack;
    logic [WB_DATA_BITS-1:0] i_wb_data;

    modport master (
        input  i_rx_data, i_rx_valid, i_tx_ready, i_wb_stall, i_wb_ack, i_wb_data,
        output o_rx_ready, o_tx_data, o_tx_valid,
               o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_tx_ready, i_wb_stall, i_wb_ack, i_wb_data,
        input  o_rx_ready, o_tx_data, o_tx_valid,
               o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel
    );

endinterface

// File: rtl/uart_wb_bridge_tx_serializer.sv
// uart_wb_tx_serializer
// Loads a DATA_BITS word plus a byte count and emits the top count_i bytes
// MSB first on a valid/ready byte stream.
// Ports:
//   clk_i    clock
//   rst_ni   synchronous active-low reset
//   load_i   load word_i/count_i (only issued while idle)
//   word_i   word to send, first byte in the top 8 bits
//   count_i  number of bytes to send
//   ready_i  downstream accepts data_o
//   data_o   current byte
//   valid_o  data_o is valid
//   done_o   pulses on the handshake of the last byte
module uart_wb_tx_serializer #(
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned CNT_W     = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [DATA_BITS-1:0] word_i,
    input  logic [CNT_W-1:0]     count_i,
    input  logic                 ready_i,
    output logic [7:0]           data_o,
    output logic                 valid_o,
    output logic                 done_o
);
    logic [DATA_BITS-1:0] word_q, word_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 valid_q, valid_d;

    always_comb begin
        word_d  = word_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i) begin
            word_d  = word_i;
            cnt_d   = count_i;
            valid_d = (count_i != '0);
        end else if (valid_q && ready_i) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                valid_d = 1'b0;
            end else begin
                word_d = word_q << 8;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            word_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = word_q[DATA_BITS-1 -: 8];
    assign valid_o = valid_q;
    assign done_o  = valid_q && ready_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge
// Byte-stream to pipelined Wishbone master bridge. Frames:
//   'W' addr[MSB..LSB] data[MSB..LSB]  -> Wishbone write, responds 'K'
//   'R' addr[MSB..LSB]                 -> Wishbone read, responds data MSB first
// Other bytes seen in IDLE are consumed and dropped.
// Optional macro UART_WB_TIMEOUT_EN: abort a bus cycle TIMEOUT_CYCLES after
// stb issue, respond 'T' and return to IDLE.
// Ports:
//   i_controller_clk  sole clock
//   i_rst_n           synchronous active-low reset
//   bus               uart_wb_bridge_if.master (UART streams + Wishbone)
//   o_busy            high in any state but IDLE
module uart_wb_bridge
    import uart_wb_bridge_pkg::*;
#(
    parameter int unsigned WB_ADDR_BITS   = 32,
    parameter int unsigned WB_DATA_BITS   = 32,
    parameter int unsigned WB_SEL_BITS    = WB_DATA_BITS / 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               i_controller_clk,
    input  logic               i_rst_n,
    uart_wb_bridge_if.master   bus,
    output logic               o_busy
);
    localparam int unsigned ADDR_BYTES = bytes_for_bits(WB_ADDR_BITS);
    localparam int unsigned DATA_BYTES = WB_DATA_BITS / 8;
    localparam int unsigned ASH_W      = ADDR_BYTES * 8;
    localparam int unsigned MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int unsigned CNT_W      = $clog2(MAX_BYTES + 1);

    logic [2:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ASH_W-1:0]        addr_q, addr_d;
    logic [WB_DATA_BITS-1:0] wdata_q, wdata_d;
    logic                    cyc_q, cyc_d;
    logic                    stb_q, stb_d;

    logic                    rx_fire;
    logic                    ack_done;
    logic                    ser_load;
    logic [WB_DATA_BITS-1:0] ser_word;
    logic [CNT_W-1:0]        ser_count;
    logic                    ser_done;

    assign bus.o_rx_ready = (state_q == ST_IDLE) || (state_q == ST_GET_ADDR) ||
                            (state_q == ST_GET_DATA);
    assign rx_fire        = bus.i_rx_valid && bus.o_rx_ready;

`ifdef UART_WB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            in_bus;

    assign in_bus   = (state_q == ST_WB_REQ) || (state_q == ST_WB_WAIT);
    // Zero outside the bus phase, so it starts at 0 on the stb issue cycle.
    assign to_cnt_d = in_bus ? to_cnt_q + TO_W'(1) : '0;

    always_ff @(posedge i_controller_clk) begin
        if (!i_rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        ack_done  = 1'b0;
        ser_load  = 1'b0;
        ser_word  = '0;
        ser_count = '0;

        case (state_q)
            ST_IDLE: begin
                if (rx_fire) begin
                    if (bus.i_rx_data == CMD_WR || bus.i_rx_data == CMD_RD) begin
                        we_d    = (bus.i_rx_data == CMD_WR);
                        cnt_d   = '0;
                        state_d = ST_GET_ADDR;
                    end
                end
            end
            ST_GET_ADDR: begin
                if (rx_fire) begin
                    addr_d = (addr_q << 8) | ASH_W'(bus.i_rx_data);
                    if (cnt_q == CNT_W'(ADDR_BYTES - 1)) begin
                        cnt_d = '0;
                        if (we_q) begin
                            state_d = ST_GET_DATA;
                        end else begin
                            state_d = ST_WB_REQ;
                            cyc_d   = 1'b1;
                            stb_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_GET_DATA: begin
                if (rx_fire) begin
                    wdata_d = (wdata_q << 8) | WB_DATA_BITS'(bus.i_rx_data);
                    if (cnt_q == CNT_W'(DATA_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_WB_REQ;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_WB_REQ: begin
                if (!bus.i_wb_stall) begin
                    stb_d = 1'b0;
                    // An ack on the acceptance cycle completes the transfer directly.
                    if (bus.i_wb_ack) begin
                        ack_done = 1'b1;
                    end else begin
                        state_d = ST_WB_WAIT;
                    end
                end
            end
            ST_WB_WAIT: begin
                if (bus.i_wb_ack) begin
                    ack_done = 1'b1;
                end
            end
            ST_SEND_RESP: begin
                if (ser_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase

        if (ack_done) begin
            cyc_d    = 1'b0;
            state_d  = ST_SEND_RESP;
            ser_load = 1'b1;
            if (we_q) begin
                ser_word  = WB_DATA_BITS'(RSP_OK) << (WB_DATA_BITS - 8);
                ser_count = CNT_W'(1);
            end else begin
                ser_word  = bus.i_wb_data;
                ser_count = CNT_W'(DATA_BYTES);
            end
        end

`ifdef UART_WB_TIMEOUT_EN
        // An ack on the expiry cycle still wins over the abort.
        if (in_bus && !ack_done && to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            cyc_d     = 1'b0;
            stb_d     = 1'b0;
            state_d   = ST_SEND_RESP;
            ser_load  = 1'b1;
            ser_word  = WB_DATA_BITS'(RSP_TO) << (WB_DATA_BITS - 8);
            ser_count = CNT_W'(1);
        end
`endif
    end

    always_ff @(posedge i_controller_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
        end
    end

    uart_wb_tx_serializer #(
        .DATA_BITS (WB_DATA_BITS),
        .CNT_W     (CNT_W)
    ) u_tx_ser (
        .clk_i   (i_controller_clk),
        .rst_ni  (i_rst_n),
        .load_i  (ser_load),
        .word_i  (ser_word),
        .count_i (ser_count),
        .ready_i (bus.i_tx_ready),
        .data_o  (bus.o_tx_data),
        .valid_o (bus.o_tx_valid),
        .done_o  (ser_done)
    );

    assign bus.o_wb_cyc  = cyc_q;
    assign bus.o_wb_stb  = stb_q;
    assign bus.o_wb_we   = we_q;
    assign bus.o_wb_addr = addr_q[WB_ADDR_BITS-1:0];
    assign bus.o_wb_data = wdata_q;
    assign bus.o_wb_sel  = '1;
    assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_wb_bridge.sv
// tb_uart_wb_bridge
// Self-checking bench for uart_wb_bridge (32-bit address and data).
// Define UART_WB_TIMEOUT_EN to also exercise the timeout path (TIMEOUT_CYCLES=16).
module tb_uart_wb_bridge;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   passed;
    int   total;

    always #5 clk = ~clk;

    uart_wb_bridge_if #(.WB_ADDR_BITS(32), .WB_DATA_BITS(32)) bus ();

    uart_wb_bridge #(
        .WB_ADDR_BITS   (32),
        .WB_DATA_BITS   (32),
        .WB_SEL_BITS    (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_controller_clk (clk),
        .i_rst_n          (rst_n),
        .bus              (bus),
        .o_busy           (busy)
    );

    // ---------------- reference model ----------------
    // Parses a frame the way a host would: skip non-command bytes, then
    // 4 address bytes (MSB first) and, for 'W', 4 data bytes.
    task automatic model_frame(input logic [7:0] fr[$], input logic [31:0] rdata,
                               output logic [31:0] ea, output logic [31:0] ed,
                               output logic ewe, output logic [7:0] etx[$]);
        int k;
        k = 0; ea = 0; ed = 0; ewe = 0; etx = {};
        while (k < fr.size() && fr[k] != 8'h57 && fr[k] != 8'h52) k++;
        if (k >= fr.size()) return;
        ewe = (fr[k] == 8'h57);
        k++;
        for (int i = 0; i < 4; i++) ea = ea * 256 + 32'(fr[k + i]);
        k += 4;
        if (ewe) begin
            for (int i = 0; i < 4; i++) ed = ed * 256 + 32'(fr[k + i]);
            etx.push_back(8'h4B);
        end else begin
            for (int i = 0; i < 4; i++) etx.push_back(8'((rdata >> (24 - 8 * i)) & 32'hFF));
        end
    endtask

    // ---------------- drivers (all start and end at a negedge) ----------------
    task automatic send_frame(input logic [7:0] fr[$], output bit ok);
        int guard;
        ok = 1;
        foreach (fr[i]) begin
            bus.i_rx_data  = fr[i];
            bus.i_rx_valid = 1'b1;
            guard = 0;
            while (!bus.o_rx_ready && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (!bus.o_rx_ready) ok = 0;
            @(negedge clk);
        end
        bus.i_rx_valid = 1'b0;
    endtask

    // ack_dly = 0 means ack on the acceptance cycle
    task automatic wb_serve(input int stall_n, input int ack_dly, input logic [31:0] rdata,
                            output logic [31:0] addr, output logic [31:0] wdata,
                            output logic we, output int stb_cycles, output int rdy_busy,
                            output bit ok);
        int guard;
        ok = 1; stb_cycles = 0; rdy_busy = 0; guard = 0;
        addr = 'x; wdata = 'x; we = 'x;
        while (!(bus.o_wb_cyc && bus.o_wb_stb) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!(bus.o_wb_cyc && bus.o_wb_stb)) begin
            ok = 0;
            return;
        end
        for (int i = 0; i < stall_n; i++) begin
            bus.i_wb_stall = 1'b1;
            if (bus.o_wb_stb) stb_cycles++;
            if (bus.o_rx_ready) rdy_busy++;
            @(negedge clk);
        end
        bus.i_wb_stall = 1'b0;
        if (bus.o_wb_stb) stb_cycles++;
        if (bus.o_rx_ready) rdy_busy++;
        addr = bus.o_wb_addr; wdata = bus.o_wb_data; we = bus.o_wb_we;
        if (ack_dly == 0) begin
            bus.i_wb_ack  = 1'b1;
            bus.i_wb_data = rdata;
        end
        @(negedge clk);
        if (ack_dly != 0) begin
            for (int i = 1; i < ack_dly; i++) begin
                if (bus.o_wb_stb) stb_cycles++;
                if (bus.o_rx_ready) rdy_busy++;
                @(negedge clk);
            end
            bus.i_wb_ack  = 1'b1;
            bus.i_wb_data = rdata;
            @(negedge clk);
        end
        bus.i_wb_ack  = 1'b0;
        bus.i_wb_data = $urandom;
    endtask

    task automatic collect_tx(input int n, input bit toggle, output logic [7:0] got[$],
                              output bit ok);
        int guard;
        bit phase;
        got = {}; guard = 0; phase = 0;
        while (got.size() < n && guard < 400) begin
            bus.i_tx_ready = toggle ? phase : 1'b1;
            phase = ~phase;
            if (bus.o_tx_valid && bus.i_tx_ready) got.push_back(bus.o_tx_data);
            @(negedge clk);
            guard++;
        end
        bus.i_tx_ready = 1'b0;
        ok = (got.size() == n);
    endtask

    task automatic run_frame(input logic [7:0] fr[$], input int stall_n, input int ack_dly,
                             input logic [31:0] rdata, input bit toggle, input bit hold_rx,
                             input int n_tx, output logic [31:0] addr, output logic [31:0] wdata,
                             output logic we, output int stb_cycles, output int rdy_busy,
                             output logic lat_valid, output logic lat_cyc,
                             output logic [7:0] got[$], output bit ok);
        bit ok1, ok2, ok3;
        send_frame(fr, ok1);
        if (hold_rx) begin
            bus.i_rx_data  = 8'h41;
            bus.i_rx_valid = 1'b1;
        end
        wb_serve(stall_n, ack_dly, rdata, addr, wdata, we, stb_cycles, rdy_busy, ok2);
        lat_valid = bus.o_tx_valid;
        lat_cyc   = bus.o_wb_cyc;
        collect_tx(n_tx, toggle, got, ok3);
        ok = ok1 && ok2 && ok3;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.o_wb_cyc !== 1'b0) $display("FAIL reset_cyc: got %b want 0", bus.o_wb_cyc); else passed++;
        total++; if (bus.o_wb_stb !== 1'b0) $display("FAIL reset_stb: got %b want 0", bus.o_wb_stb); else passed++;
        total++; if (bus.o_wb_we !== 1'b0) $display("FAIL reset_we: got %b want 0", bus.o_wb_we); else passed++;
        total++; if (bus.o_wb_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", bus.o_wb_addr); else passed++;
        total++; if (bus.o_wb_data !== 32'h0) $display("FAIL reset_data: got %h want 0", bus.o_wb_data); else passed++;
        total++; if (bus.o_tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", bus.o_tx_valid); else passed++;
        total++; if (bus.o_tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", bus.o_tx_data); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (bus.o_wb_sel !== 4'hF) $display("FAIL reset_sel: got %h want f", bus.o_wb_sel); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        logic [7:0] fr[$], got[$];
        logic [31:0] a, d;
        logic we, lv, lc;
        int sc, rb;
        bit ok;
        fr = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_frame(fr, 0, 2, 32'h1234_5678, 0, 0, 1, a, d, we, sc, rb, lv, lc, got, ok);
        total++; if (!ok) $display("FAIL write_handshake: bounded wait expired"); else passed++;
        total++; if (a !== 32'h10) $display("FAIL write_addr: got %h want 00000010", a); else passed++;
        total++; if (d !== 32'hDEADBEEF) $display("FAIL write_data: got %h want deadbeef", d); else passed++;
        total++; if (we !== 1'b1) $display("FAIL write_we: got %b want 1", we); else passed++;
        total++; if (got.size() != 1 || got[0] !== 8'h4B) $display("FAIL write_resp: got %0d bytes first %h want 1 byte 4b", got.size(), got.size() ? got[0] : 8'h00); else passed++;
        total++; if (bus.o_tx_valid !== 1'b0 || busy !== 1'b0) $display("FAIL write_idle_after: tx_valid %b busy %b want 0 0", bus.o_tx_valid, busy); else passed++;
    endtask

    task automatic test_read();
        logic [7:0] fr[$], got[$];
        logic [31:0] a, d;
        logic we, lv, lc;
        int sc, rb;
        bit ok, good;
        logic [7:0] exp [4];
        exp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        fr = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h10};
        run_frame(fr, 0, 5, 32'hDEADBEEF, 0, 0, 4, a, d, we, sc, rb, lv, lc, got, ok);
        total++; if (!ok) $display("FAIL read_handshake: bounded wait expired"); else passed++;
        total++; if (a !== 32'h10 || we !== 1'b0) $display("FAIL read_req: addr %h we %b want 00000010 0", a, we); else passed++;
        total++; if (lv !== 1'b1 || lc !== 1'b0) $display("FAIL read_latency: tx_valid %b cyc %b after ack want 1 0", lv, lc); else passed++;
        good = (got.size() == 4);
        for (int i = 0; i < 4 && good; i++) if (got[i] !== exp[i]) good = 0;
        total++; if (!good) $display("FAIL read_resp: got %0d bytes %p want de ad be ef", got.size(), got); else passed++;
    endtask

    task automatic test_stall_backpressure();
        logic [7:0] fr[$], got[$], etx[$];
        logic [31:0] a, d, ea, ed, rd;
        logic we, ewe, lv, lc;
        int sc, rb;
        bit ok, good;
        ea = $urandom; rd = $urandom;
        fr = '{8'h52, ea[31:24], ea[23:16], ea[15:8], ea[7:0]};
        model_frame(fr, rd, ea, ed, ewe, etx);
        run_frame(fr, 7, 1, rd, 1, 1, 4, a, d, we, sc, rb, lv, lc, got, ok);
        total++; if (!ok) $display("FAIL stall_handshake: bounded wait expired"); else passed++;
        total++; if (sc != 8) $display("FAIL stall_stb_cycles: got %0d want 8", sc); else passed++;
        total++; if (rb != 0) $display("FAIL stall_rx_ready_busy: got %0d cycles want 0", rb); else passed++;
        total++; if (a !== ea) $display("FAIL stall_addr: got %h want %h", a, ea); else passed++;
        good = (got.size() == etx.size());
        for (int i = 0; i < etx.size() && good; i++) if (got[i] !== etx[i]) good = 0;
        total++; if (!good) $display("FAIL stall_resp: got %p want %p", got, etx); else passed++;
        // the held junk byte is taken once IDLE is reached and dropped
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL stall_junk_dropped: busy %b want 0", busy); else passed++;
    endtask

    task automatic test_junk();
        logic [7:0] fr[$], got[$];
        logic [31:0] a, d;
        logic we, lv, lc;
        int sc, rb;
        bit ok;
        fr = '{8'h41, 8'h57, 8'h00, 8'h00, 8'h00, 8'h24, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        run_frame(fr, 1, 3, 32'h0, 0, 0, 1, a, d, we, sc, rb, lv, lc, got, ok);
        total++; if (!ok) $display("FAIL junk_handshake: bounded wait expired"); else passed++;
        total++; if (a !== 32'h24 || d !== 32'hCAFEF00D || we !== 1'b1) $display("FAIL junk_write: addr %h data %h we %b want 00000024 cafef00d 1", a, d, we); else passed++;
        total++; if (got.size() != 1 || got[0] !== 8'h4B) $display("FAIL junk_resp: got %p want 4b", got); else passed++;
    endtask

    task automatic test_same_cycle_ack();
        logic [7:0] fr[$], got[$];
        logic [31:0] a, d;
        logic we, lv, lc;
        int sc, rb;
        bit ok, good;
        logic [7:0] exp [4];
        exp = '{8'h01, 8'h23, 8'h45, 8'h67};
        fr = '{8'h52, 8'h80, 8'h00, 8'h00, 8'h04};
        run_frame(fr, 2, 0, 32'h01234567, 0, 0, 4, a, d, we, sc, rb, lv, lc, got, ok);
        total++; if (!ok) $display("FAIL same_ack_handshake: bounded wait expired"); else passed++;
        total++; if (sc != 3) $display("FAIL same_ack_stb_cycles: got %0d want 3", sc); else passed++;
        total++; if (lv !== 1'b1 || lc !== 1'b0) $display("FAIL same_ack_latency: tx_valid %b cyc %b want 1 0", lv, lc); else passed++;
        good = (got.size() == 4);
        for (int i = 0; i < 4 && good; i++) if (got[i] !== exp[i]) good = 0;
        total++; if (!good) $display("FAIL same_ack_resp: got %p want 01 23 45 67", got); else passed++;
    endtask

    task automatic test_reset_midtxn();
        logic [7:0] fr[$];
        bit ok;
        int guard, seen;
        fr = '{8'h52, 8'h00, 8'h00, 8'h01, 8'h00};
        send_frame(fr, ok);
        guard = 0;
        while (!(bus.o_wb_cyc && bus.o_wb_stb) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        total++; if (!ok || bus.o_wb_cyc !== 1'b1 || bus.o_wb_stb !== 1'b0) $display("FAIL midrst_wait_state: ok %b cyc %b stb %b want 1 1 0", ok, bus.o_wb_cyc, bus.o_wb_stb); else passed++;
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (bus.o_wb_cyc !== 1'b0 || bus.o_wb_stb !== 1'b0 || busy !== 1'b0) $display("FAIL midrst_drop: cyc %b stb %b busy %b want 0 0 0", bus.o_wb_cyc, bus.o_wb_stb, busy); else passed++;
        rst_n = 1'b1;
        bus.i_tx_ready = 1'b1;
        bus.i_wb_ack   = 1'b1;
        @(negedge clk);
        bus.i_wb_ack = 1'b0;
        seen = 0;
        repeat (8) begin
            if (bus.o_tx_valid) seen++;
            @(negedge clk);
        end
        bus.i_tx_ready = 1'b0;
        total++; if (seen != 0) $display("FAIL midrst_no_tx: got %0d valid cycles want 0", seen); else passed++;
    endtask

`ifdef UART_WB_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] fr[$], got[$];
        bit ok, ok2;
        int guard, n, seen;
        fr = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h40};
        send_frame(fr, ok);
        guard = 0;
        while (!(bus.o_wb_cyc && bus.o_wb_stb) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        n = 0;
        while (bus.o_wb_cyc && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++; if (!ok || n != 16) $display("FAIL timeout_cycles: got %0d want 16", n); else passed++;
        collect_tx(1, 0, got, ok2);
        total++; if (!ok2 || got[0] !== 8'h54) $display("FAIL timeout_resp: got %p want 54", got); else passed++;
        bus.i_tx_ready = 1'b1;
        bus.i_wb_ack   = 1'b1;
        @(negedge clk);
        bus.i_wb_ack = 1'b0;
        seen = 0;
        repeat (6) begin
            if (bus.o_tx_valid || busy) seen++;
            @(negedge clk);
        end
        bus.i_tx_ready = 1'b0;
        total++; if (seen != 0) $display("FAIL timeout_late_ack: got %0d active cycles want 0", seen); else passed++;
    endtask
`endif

    task automatic test_random();
        logic [7:0] fr[$], got[$], etx[$];
        logic [31:0] a, d, ea, ed, rd, ra, rdat;
        logic we, ewe, lv, lc;
        logic [7:0] j;
        int sc, rb, stall, ackd;
        bit ok, good, is_wr, tog;
        for (int it = 0; it < 12; it++) begin
            is_wr = 1'($urandom_range(0, 1));
            ra    = $urandom;
            rdat  = $urandom;
            rd    = $urandom;
            stall = $urandom_range(0, 3);
            ackd  = $urandom_range(0, 4);
            tog   = 1'($urandom_range(0, 1));
            fr = {};
            if ($urandom_range(0, 3) == 0) begin
                j = 8'($urandom_range(0, 255));
                if (j == 8'h57 || j == 8'h52) j = 8'h00;
                fr.push_back(j);
            end
            fr.push_back(is_wr ? 8'h57 : 8'h52);
            for (int i = 0; i < 4; i++) fr.push_back(8'(ra >> (24 - 8 * i)));
            if (is_wr) for (int i = 0; i < 4; i++) fr.push_back(8'(rdat >> (24 - 8 * i)));
            model_frame(fr, rd, ea, ed, ewe, etx);
            run_frame(fr, stall, ackd, rd, tog, 0, etx.size(), a, d, we, sc, rb, lv, lc, got, ok);
            total++; if (!ok) $display("FAIL rand%0d_handshake: bounded wait expired", it); else passed++;
            total++; if (a !== ea || we !== ewe) $display("FAIL rand%0d_req: addr %h we %b want %h %b", it, a, we, ea, ewe); else passed++;
            if (ewe) begin
                total++; if (d !== ed) $display("FAIL rand%0d_wdata: got %h want %h", it, d, ed); else passed++;
            end
            total++; if (sc != stall + 1) $display("FAIL rand%0d_stb_cycles: got %0d want %0d", it, sc, stall + 1); else passed++;
            total++; if (lv !== 1'b1) $display("FAIL rand%0d_latency: tx_valid %b want 1", it, lv); else passed++;
            good = (got.size() == etx.size());
            for (int i = 0; i < etx.size() && good; i++) if (got[i] !== etx[i]) good = 0;
            total++; if (!good) $display("FAIL rand%0d_resp: got %p want %p", it, got, etx); else passed++;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n          = 1'b0;
        bus.i_rx_data  = 8'h00;
        bus.i_rx_valid = 1'b0;
        bus.i_tx_ready = 1'b0;
        bus.i_wb_stall = 1'b0;
        bus.i_wb_ack   = 1'b0;
        bus.i_wb_data  = 32'h0;
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_stall_backpressure();
        test_junk();
        test_same_cycle_ack();
        test_reset_midtxn();
`ifdef UART_WB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
